// File: rtl/gpio_cfg_regbank_pkg.sv
// Shared definitions for the GPIO configuration register bank.
// Holds the default GPIO field positions, register geometry, the register
// word type, the well-known config register addresses and a small width helper.
package gpio_cfg_regbank_pkg;

  // GPIO write-bus field layout
  localparam int DEF_GPIO_W   = 25;
  localparam int DEF_WCLK_BIT = 24;
  localparam int DEF_ADDR_LSB = 0;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_LSB = 16;
  localparam int DEF_DATA_W   = 8;

  // Register geometry
  localparam int DEF_BYTES      = 2;
  localparam int REG_W          = DEF_BYTES * DEF_DATA_W;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_NUM_STATUS = 8;

  // Indirect table access
  localparam int DEF_TBL_ADDR_REG   = 12;
  localparam int DEF_TBL_DATA_REG   = 13;
  localparam int DEF_TBL_DEPTH_LOG2 = 12;

  typedef logic [REG_W-1:0] cfg_word_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gpio_cfg_regbank_wclk_sync.sv
// gpio_wclk_sync: brings the asynchronous GPIO write bus into the clk domain.
// The whole bus passes through two sync flops; a third flop on the w_clk bit
// gives rising-edge detection. The detected event and the address/data fields
// (taken from the second sync stage) are registered once more on the way out.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   gpio_in   - raw GPIO bus
//   wr_ev     - one-cycle write event
//   wr_addr   - address field captured with the event
//   wr_data   - data byte captured with the event
module gpio_wclk_sync #(
  parameter int GPIO_W   = 25,
  parameter int WCLK_BIT = 24,
  parameter int ADDR_LSB = 0,
  parameter int ADDR_W   = 16,
  parameter int DATA_LSB = 16,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              wr_ev,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  // w_clk resets high in every stage so a strobe held high across reset
  // release is not seen as a rising edge.
  localparam logic [GPIO_W-1:0] SYNC_RST = GPIO_W'(1) << WCLK_BIT;

  logic [GPIO_W-1:0] sync1;
  logic [GPIO_W-1:0] sync2;
  logic              wclk_d3;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes this a shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= SYNC_RST;
      sync2   <= SYNC_RST;
      wclk_d3 <= 1'b1;
      wr_ev   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      sync1   <= gpio_in;
      sync2   <= sync1;
      wclk_d3 <= sync2[WCLK_BIT];
      // Registered edge detect: aligns the event with its address/data and
      // places register updates three edges after w_clk is first sampled.
      wr_ev   <= sync2[WCLK_BIT] & ~wclk_d3;
      wr_addr <= sync2[ADDR_LSB +: ADDR_W];
      wr_data <= sync2[DATA_LSB +: DATA_W];
    end
  end

endmodule

// File: rtl/gpio_cfg_regbank.sv
// gpio_cfg_regbank: configuration register bank behind the PS GPIO write bus.
// Byte writes shift into multi-byte config registers MSB-first, trigger
// addresses emit one-cycle pulses, an addr/data register pair streams words
// into an external table with pointer auto-increment, and a registered
// readback mux serves config and status words.
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   gpio_in     - raw GPIO write bus (w_clk strobe, address, data byte)
//   cfg_regs    - flattened config registers, reg i at [i*REG_W +: REG_W]
//   trig_pulse  - one-cycle pulse per write to a trigger address
//   tbl_wr      - table write strobe
//   tbl_addr    - table write address (tracks the pointer register)
//   tbl_data    - table write data
//   status_in   - read-only status words
//   rd_addr     - readback address
//   rd_data     - readback data, one cycle after rd_addr
module gpio_cfg_regbank
  import gpio_cfg_regbank_pkg::*;
#(
  parameter int GPIO_W         = DEF_GPIO_W,
  parameter int WCLK_BIT       = DEF_WCLK_BIT,
  parameter int ADDR_LSB       = DEF_ADDR_LSB,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_LSB       = DEF_DATA_LSB,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int BYTES          = DEF_BYTES,
  parameter int NUM_REGS       = DEF_NUM_REGS,
  parameter int NUM_STATUS     = DEF_NUM_STATUS,
  parameter logic [NUM_REGS-1:0] TRIG_MASK = '0,
  parameter int TBL_ADDR_REG   = DEF_TBL_ADDR_REG,
  parameter int TBL_DATA_REG   = DEF_TBL_DATA_REG,
  parameter int TBL_DEPTH_LOG2 = DEF_TBL_DEPTH_LOG2,
  localparam int RW            = BYTES * DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [GPIO_W-1:0]          gpio_in,
  output logic [NUM_REGS*RW-1:0]     cfg_regs,
  output logic [NUM_REGS-1:0]        trig_pulse,
  output logic                       tbl_wr,
  output logic [TBL_DEPTH_LOG2-1:0]  tbl_addr,
  output logic [RW-1:0]              tbl_data,
  input  logic [NUM_STATUS*RW-1:0]   status_in,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [RW-1:0]              rd_data
);

  localparam int IDX_W  = clog2_min1(NUM_REGS);
  localparam int SIDX_W = clog2_min1(NUM_STATUS);
  localparam int CNT_W  = clog2_min1(BYTES);

  // ---------------------------------------------------------------------------
  // Write bus synchroniser
  // ---------------------------------------------------------------------------
  logic              wr_ev;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  gpio_wclk_sync #(
    .GPIO_W   (GPIO_W),
    .WCLK_BIT (WCLK_BIT),
    .ADDR_LSB (ADDR_LSB),
    .ADDR_W   (ADDR_W),
    .DATA_LSB (DATA_LSB),
    .DATA_W   (DATA_W)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .gpio_in (gpio_in),
    .wr_ev   (wr_ev),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  logic             wr_hit;
  logic [IDX_W-1:0] wr_idx;
  logic             hit_tbl_addr;
  logic             hit_tbl_data;

  // NOTE: every combinational output gets a value on every path (here by
  // plain full assignment), so no latch can be inferred.
  always_comb begin
    wr_hit       = wr_ev && (32'(wr_addr) < NUM_REGS);
    wr_idx       = wr_addr[IDX_W-1:0];
    hit_tbl_addr = wr_hit && (32'(wr_idx) == TBL_ADDR_REG);
    hit_tbl_data = wr_hit && (32'(wr_idx) == TBL_DATA_REG);
  end

  // ---------------------------------------------------------------------------
  // Config registers
  // ---------------------------------------------------------------------------
  logic [RW-1:0] cfg_mem [NUM_REGS];

  // NOTE: cfg_mem is a bank of flops feeding live outputs, not a RAM, so it
  // is reset like any other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cfg_mem[i] <= '0;
    end else begin
      // Pointer write-back the cycle after a table write; a host write in the
      // same cycle is placed second so it takes precedence.
      if (tbl_wr)
        cfg_mem[TBL_ADDR_REG][TBL_DEPTH_LOG2-1:0] <= tbl_addr + TBL_DEPTH_LOG2'(1);
      // Shift the new byte in at the LSB; the oldest byte falls off the top.
      if (wr_hit)
        cfg_mem[wr_idx] <= RW'({cfg_mem[wr_idx], wr_data});
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_regs[g*RW +: RW] = cfg_mem[g];
  end

  // ---------------------------------------------------------------------------
  // Trigger pulses: recomputed every cycle, so they can never stretch.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) trig_pulse <= '0;
    else     trig_pulse <= wr_hit ? (TRIG_MASK & (NUM_REGS'(1) << wr_idx)) : '0;
  end

  // ---------------------------------------------------------------------------
  // Table sequencer
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] byte_cnt;
  logic             tbl_pend;   // word completed this cycle, issue next cycle

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      tbl_pend <= 1'b0;
    end else begin
      tbl_pend <= 1'b0;
      if (hit_tbl_addr) begin
        byte_cnt <= '0;
      end else if (hit_tbl_data) begin
        if (byte_cnt == CNT_W'(BYTES - 1)) begin
          byte_cnt <= '0;
          tbl_pend <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_wr   <= 1'b0;
      tbl_addr <= '0;
      tbl_data <= '0;
    end else begin
      tbl_wr   <= tbl_pend;
      tbl_addr <= cfg_mem[TBL_ADDR_REG][TBL_DEPTH_LOG2-1:0];
      if (tbl_pend) tbl_data <= cfg_mem[TBL_DATA_REG];
    end
  end

  // ---------------------------------------------------------------------------
  // Readback mux: samples cfg_mem before any same-edge write lands.
  // ---------------------------------------------------------------------------
  logic [SIDX_W-1:0] s_idx;

  always_comb begin
    s_idx = SIDX_W'(32'(rd_addr) - NUM_REGS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (32'(rd_addr) < NUM_REGS) begin
      rd_data <= cfg_mem[rd_addr[IDX_W-1:0]];
    end else if (32'(rd_addr) < NUM_REGS + NUM_STATUS) begin
      rd_data <= status_in[int'(s_idx)*RW +: RW];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_gpio_cfg_regbank.sv
`timescale 1ns/1ps
module tb_gpio_cfg_regbank;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [24:0]   gpio_in;
  logic [511:0]  cfg_regs;
  logic [31:0]   trig_pulse;
  logic          tbl_wr;
  logic [11:0]   tbl_addr;
  logic [15:0]   tbl_data;
  logic [127:0]  status_in;
  logic [15:0]   rd_addr;
  logic [15:0]   rd_data;

  gpio_cfg_regbank #(
    .TRIG_MASK (32'h0000_0001)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gpio_in    (gpio_in),
    .cfg_regs   (cfg_regs),
    .trig_pulse (trig_pulse),
    .tbl_wr     (tbl_wr),
    .tbl_addr   (tbl_addr),
    .tbl_data   (tbl_data),
    .status_in  (status_in),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Table write monitor
  typedef struct {
    logic [11:0] a;
    logic [15:0] d;
  } tbl_ev_t;
  tbl_ev_t tq[$];

  always @(negedge clk) begin
    if (tbl_wr) tq.push_back('{tbl_addr, tbl_data});
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [24:0] mk_gpio(input logic [15:0] a, input logic [7:0] d, input logic w);
    return {w, d, a};
  endfunction

  function automatic logic [15:0] cfg_word(input int i);
    return cfg_regs[i*16 +: 16];
  endfunction

  // One host byte write honouring the strobe contract.
  task automatic gpio_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    gpio_in = mk_gpio(a, d, 1'b1);
    repeat (3) @(negedge clk);
    gpio_in[24] = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [15:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk);
    #1;
    check(name, rd_data, exp);
  endtask

  typedef struct {
    bit          do_wr;
    logic [15:0] wa;
    logic [7:0]  wd;
    logic [15:0] ra;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          bad;
    logic [15:0]   pulse_seen;
    logic          other_trig;
    logic [511:0]  snap;

    vecs[0]  = '{1'b1, 16'd3,      8'hAB, 16'd3,      16'h00AB, "wr3_byte0"};
    vecs[1]  = '{1'b1, 16'd3,      8'hCD, 16'd3,      16'hABCD, "wr3_byte1"};
    vecs[2]  = '{1'b1, 16'd7,      8'h12, 16'd7,      16'h0012, "wr7_byte0"};
    vecs[3]  = '{1'b1, 16'd7,      8'h34, 16'd7,      16'h1234, "wr7_byte1"};
    vecs[4]  = '{1'b1, 16'd7,      8'h56, 16'd7,      16'h3456, "wr7_shiftout"};
    vecs[5]  = '{1'b1, 16'd35,     8'hFF, 16'd3,      16'hABCD, "wr_status_alias3"};
    vecs[6]  = '{1'b1, 16'd31,     8'h9A, 16'd31,     16'h009A, "wr_last_reg"};
    vecs[7]  = '{1'b1, 16'hFFFF,   8'h11, 16'd31,     16'h009A, "wr_unmapped_alias31"};
    vecs[8]  = '{1'b1, 16'd32,     8'h77, 16'd32,     16'h5A00, "rd_status0"};
    vecs[9]  = '{1'b0, 16'd0,      8'h00, 16'd33,     16'h5A01, "rd_status1"};
    vecs[10] = '{1'b0, 16'd0,      8'h00, 16'd39,     16'h5A07, "rd_status7"};
    vecs[11] = '{1'b0, 16'd0,      8'h00, 16'd40,     16'h0000, "rd_past_status"};
    vecs[12] = '{1'b0, 16'd0,      8'h00, 16'hFFFF,   16'h0000, "rd_ffff"};
    vecs[13] = '{1'b0, 16'd0,      8'h00, 16'd5,      16'h0000, "rd_reset_addr5"};

    for (int i = 0; i < 8; i++) status_in[i*16 +: 16] = 16'h5A00 + 16'(i);
    rd_addr = 16'd0;

    // 1. Reset with w_clk held high: release must not produce a write.
    gpio_in = mk_gpio(16'd5, 8'h99, 1'b1);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (trig_pulse != '0 || tbl_wr) bad = 1'b1;
    end
    @(negedge clk);
    gpio_in[24] = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_no_pulse", 32'(bad), 32'd0);
    check("rst_cfg_zero", 32'(cfg_regs == '0), 32'd1);
    check("rst_tbl_addr", 32'(tbl_addr), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);

    // 2/5. Table-driven writes and readbacks.
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].do_wr) gpio_wr(vecs[i].wa, vecs[i].wd);
      rd_check(vecs[i].name, vecs[i].ra, vecs[i].exp);
    end
    check("cfg3_port", 32'(cfg_word(3)), 32'h0000ABCD);

    // Ignored writes leave every register untouched.
    snap = cfg_regs;
    gpio_wr(16'd33, 8'hEE);
    gpio_wr(16'd38, 8'hEE);
    check("ignored_writes", 32'(cfg_regs == snap), 32'd1);

    // 3. Trigger latency, pulse width, back-to-back events, and
    //    same-cycle write/read of address 0.
    @(negedge clk);
    rd_addr = 16'd0;
    gpio_in = mk_gpio(16'd0, 8'h42, 1'b0);
    pulse_seen = '0;
    other_trig = 1'b0;
    for (int k = 0; k < 16; k++) begin
      gpio_in[24] = (k < 2) || (k >= 4 && k < 6);
      @(posedge clk);
      #1;
      pulse_seen[k] = trig_pulse[0];
      if (trig_pulse[31:1] != '0) other_trig = 1'b1;
      if (k == 2) check("cfg0_before_edge3", 32'(cfg_word(0)), 32'h0000);
      if (k == 3) begin
        check("cfg0_after_edge3", 32'(cfg_word(0)), 32'h0042);
        check("rd_same_cycle_old", 32'(rd_data), 32'h0000);
      end
      if (k == 4) check("rd_after_write", 32'(rd_data), 32'h0042);
      @(negedge clk);
    end
    check("trig_pattern", 32'(pulse_seen), 32'h0088);
    check("trig_others_quiet", 32'(other_trig), 32'd0);
    check("cfg0_two_bytes", 32'(cfg_word(0)), 32'h4242);

    // 4. Table burst across the pointer wrap.
    tq.delete();
    gpio_wr(16'd12, 8'h0F);
    gpio_wr(16'd12, 8'hFF);
    check("tbl_ptr_loaded", 32'(cfg_word(12)), 32'h0FFF);
    gpio_wr(16'd13, 8'h11);
    gpio_wr(16'd13, 8'h22);
    gpio_wr(16'd13, 8'h33);
    gpio_wr(16'd13, 8'h44);
    repeat (4) @(negedge clk);
    check("tbl_wr_count", 32'(tq.size()), 32'd2);
    check("tbl0_addr", 32'((tq.size() > 0) ? tq[0].a : 12'hBAD), 32'h0FFF);
    check("tbl0_data", 32'((tq.size() > 0) ? tq[0].d : 16'hDEAD), 32'h1122);
    check("tbl1_addr", 32'((tq.size() > 1) ? tq[1].a : 12'hBAD), 32'h0000);
    check("tbl1_data", 32'((tq.size() > 1) ? tq[1].d : 16'hDEAD), 32'h3344);
    check("tbl_ptr_after", 32'(cfg_word(12)), 32'h0001);
    check("tbl_addr_after", 32'(tbl_addr), 32'h001);

    // 6. Reset in the middle of a table burst.
    tq.delete();
    gpio_wr(16'd13, 8'h77);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_ptr", 32'(cfg_word(12)), 32'h0000);
    check("midrst_data_reg", 32'(cfg_word(13)), 32'h0000);
    check("midrst_no_tbl_wr", 32'(tq.size()), 32'd0);
    gpio_wr(16'd13, 8'hBE);
    check("midrst_no_early_wr", 32'(tq.size()), 32'd0);
    gpio_wr(16'd13, 8'hEF);
    repeat (4) @(negedge clk);
    check("fresh_tbl_count", 32'(tq.size()), 32'd1);
    check("fresh_tbl_addr", 32'((tq.size() > 0) ? tq[0].a : 12'hBAD), 32'h0000);
    check("fresh_tbl_data", 32'((tq.size() > 0) ? tq[0].d : 16'hDEAD), 32'hBEEF);
    check("fresh_ptr_after", 32'(cfg_word(12)), 32'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
